// File: rtl/effect_chain_scheduler.sv
// Sequences one audio sample through a chain of start/done effect stages, with a per-stage
// watchdog bypass, a one-deep early-sample buffer and between-sample config application.
module effect_chain_scheduler #(
  parameter int unsigned NumStages   = 2,
  parameter int unsigned Timeout     = 64,
  parameter int unsigned ResetCycles = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sample_ready_i,
  input  logic [11:0]             sample_in_i,
  input  logic [4:0]              delay_amount_req_i,
  input  logic                    enable_req_i,
  output logic [NumStages-1:0]    stage_start_o,
  input  logic [NumStages-1:0]    stage_done_i,
  output logic [11:0]             stage_din_o,
  input  logic [12*NumStages-1:0] stage_dout_i,
  output logic                    effect_reset_o,
  output logic [4:0]              delay_amount_o,
  output logic                    effect_enable_o,
  output logic [11:0]             sample_out_o,
  output logic                    sample_valid_o,
  output logic                    busy_o,
  output logic                    timeout_flag_o,
  output logic                    overrun_flag_o
);

  localparam int unsigned CntW = $clog2(Timeout + 1);
  localparam int unsigned StW  = (NumStages > 1) ? $clog2(NumStages) : 1;
  localparam int unsigned RstW = $clog2(ResetCycles + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(Timeout);
  localparam logic [StW-1:0]  LastStage  = StW'(NumStages - 1);
  localparam logic [RstW-1:0] RstLast    = RstW'(ResetCycles - 1);

  typedef enum logic [2:0] {StIdle, StCfg, StIssue, StWait, StOut} state_e;

  state_e          state_q, state_d;
  logic [StW-1:0]  stage_q, stage_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RstW-1:0] rcnt_q, rcnt_d;
  logic [11:0]     work_q, work_d;
  logic [11:0]     buf_q, buf_d;
  logic            buf_valid_q, buf_valid_d;
  logic [11:0]     sample_out_q, sample_out_d;
  logic [4:0]      delay_q, delay_d;
  logic            enable_q, enable_d;
  logic            timeout_q, timeout_d;
  logic            overrun_q, overrun_d;

  logic            sel_done;
  logic [11:0]     sel_dout;
  logic            cfg_pending;
  logic            advance;

  always_comb begin
    sel_done = 1'b0;
    sel_dout = '0;
    for (int k = 0; k < int'(NumStages); k++) begin
      if (stage_q == StW'(k)) begin
        sel_done = stage_done_i[k];
        sel_dout = stage_dout_i[12*k +: 12];
      end
    end
  end

  assign cfg_pending = {delay_amount_req_i, enable_req_i} != {delay_q, enable_q};

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    cnt_d        = cnt_q;
    rcnt_d       = rcnt_q;
    work_d       = work_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    sample_out_d = sample_out_q;
    delay_d      = delay_q;
    enable_d     = enable_q;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;
    advance      = 1'b0;

    // Samples arriving while busy go to the one-deep buffer, or are dropped when it is full.
    if (state_q != StIdle && sample_ready_i) begin
      if (!buf_valid_q) begin
        buf_valid_d = 1'b1;
        buf_d       = sample_in_i;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (buf_valid_q) begin
          work_d  = buf_q;
          stage_d = '0;
          state_d = StIssue;
          if (sample_ready_i) begin
            buf_d = sample_in_i;
          end else begin
            buf_valid_d = 1'b0;
          end
        end else if (sample_ready_i) begin
          work_d  = sample_in_i;
          stage_d = '0;
          state_d = StIssue;
        end else if (cfg_pending) begin
          delay_d  = delay_amount_req_i;
          enable_d = enable_req_i;
          rcnt_d   = '0;
          state_d  = StCfg;
        end
      end
      StCfg: begin
        if (rcnt_q == RstLast) begin
          state_d = StIdle;
        end else begin
          rcnt_d = rcnt_q + RstW'(1);
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done seen on the first wait cycle may be left over from the previous sample.
        if (cnt_q != '0 && sel_done) begin
          work_d  = sel_dout;
          advance = 1'b1;
        end else if (cnt_q == TimeoutVal) begin
          timeout_d = 1'b1;
          advance   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (advance) begin
          if (stage_q == LastStage) begin
            state_d = StOut;
          end else begin
            stage_d = stage_q + StW'(1);
            state_d = StIssue;
          end
        end
      end
      StOut: begin
        sample_out_d = work_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      stage_q      <= '0;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      work_q       <= '0;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      sample_out_q <= '0;
      delay_q      <= '0;
      enable_q     <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      work_q       <= work_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      sample_out_q <= sample_out_d;
      delay_q      <= delay_d;
      enable_q     <= enable_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    stage_start_o = '0;
    for (int k = 0; k < int'(NumStages); k++) begin
      stage_start_o[k] = (state_q == StIssue) && (stage_q == StW'(k));
    end
  end

  assign stage_din_o     = work_q;
  assign effect_reset_o  = (state_q == StCfg);
  assign delay_amount_o  = delay_q;
  assign effect_enable_o = enable_q;
  assign sample_valid_o  = (state_q == StOut);
  assign sample_out_o    = (state_q == StOut) ? work_q : sample_out_q;
  assign busy_o          = (state_q != StIdle);
  assign timeout_flag_o  = timeout_q;
  assign overrun_flag_o  = overrun_q;

endmodule
